// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU opcode constants shared by the arbiter and its ALU
package alu_arbiter_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational add/sub, result truncated to WIDTH, unknown opcodes give zero
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] res_o
);
    assign res_o = (op_i == OP_ADD) ? a_i + b_i :
                   (op_i == OP_SUB) ? a_i - b_i : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one ALU, one transaction in flight
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [2:0]       req0_op_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [2:0]       req1_op_i,
    output logic             req1_ready_o,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_res_o,
    input  logic             rsp_ready_i,
    output logic             busy_o,
    output logic [15:0]      done_cnt_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_last;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic [15:0]      r_done_cnt;
    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [WIDTH-1:0] w_res;

    // On a tie the requester that did not own the last response wins
    assign w_idle       = (r_state == IDLE) && !rst_i;
    assign w_gnt0       = req0_valid_i && (!req1_valid_i || r_last);
    assign w_gnt1       = req1_valid_i && (!req0_valid_i || !r_last);
    assign req0_ready_o = w_idle && w_gnt0;
    assign req1_ready_o = w_idle && w_gnt1;
    assign rsp_valid_o  = (r_state == RESP);
    assign rsp_id_o     = r_id;
    assign rsp_res_o    = r_res;
    assign busy_o       = (r_state != IDLE);
    assign done_cnt_o   = r_done_cnt;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i  (r_a),
        .b_i  (r_b),
        .op_i (r_op),
        .res_o(w_res)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_res      <= '0;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (req0_ready_o || req1_ready_o) begin
                    r_state <= EXEC;
                    r_id    <= req1_ready_o;
                    r_a     <= req1_ready_o ? req1_a_i : req0_a_i;
                    r_b     <= req1_ready_o ? req1_b_i : req0_b_i;
                    r_op    <= req1_ready_o ? req1_op_i : req0_op_i;
                end
                EXEC: begin
                    r_res   <= w_res;
                    r_state <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    r_state    <= IDLE;
                    r_last     <= r_id;
                    r_done_cnt <= r_done_cnt + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, expected responses queued and checked by a separate monitor
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req0_valid_i = 1'b0;
    logic [7:0] req0_a_i = '0;
    logic [7:0] req0_b_i = '0;
    logic [2:0] req0_op_i = '0;
    logic       req0_ready_o;
    logic       req1_valid_i = 1'b0;
    logic [7:0] req1_a_i = '0;
    logic [7:0] req1_b_i = '0;
    logic [2:0] req1_op_i = '0;
    logic       req1_ready_o;
    logic       rsp_valid_o;
    logic       rsp_id_o;
    logic [7:0] rsp_res_o;
    logic       rsp_ready_i = 1'b1;
    logic       busy_o;
    logic [15:0] done_cnt_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req0_valid_i(req0_valid_i),
        .req0_a_i    (req0_a_i),
        .req0_b_i    (req0_b_i),
        .req0_op_i   (req0_op_i),
        .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i),
        .req1_a_i    (req1_a_i),
        .req1_b_i    (req1_b_i),
        .req1_op_i   (req1_op_i),
        .req1_ready_o(req1_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_res_o   (rsp_res_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o),
        .done_cnt_o  (done_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [7:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Each requester keeps valid high until it has issued its quota of transfers
    task automatic run(input int n0, input int n1, input int budget);
        int r0 = n0;
        int r1 = n1;
        int t = 0;
        req0_valid_i = (r0 > 0);
        req1_valid_i = (r1 > 0);
        while ((r0 > 0 || r1 > 0) && t < budget) begin
            @(negedge clk);
            if (req0_valid_i && req0_ready_o) r0--;
            if (req1_valid_i && req1_ready_o) r1--;
            cyc();
            req0_valid_i = (r0 > 0);
            req1_valid_i = (r1 > 0);
            t++;
        end
        if (t >= budget) chk("run_timeout", 32'(r0 + r1), 0);
    endtask

    task automatic wait_done(input logic [15:0] target, input int budget);
        int t = 0;
        while (done_cnt_o !== target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("done_cnt", done_cnt_o, target);
    endtask

    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id=%0d res=%0d expected none", rsp_id_o, rsp_res_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
                chk("rsp_res", 32'(rsp_res_o), 32'(e.res));
            end
        end
    end

    initial begin
        repeat (3) cyc();
        req0_valid_i = 1'b1;
        req0_a_i = 8'd50;
        req0_b_i = 8'd3;
        req0_op_i = OP_ADD;
        #1;
        chk("ready0_in_reset", req0_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_id", rsp_id_o, 0);
        chk("rst_rsp_res", rsp_res_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_cnt_o, 0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        chk("single_ready0", req0_ready_o, 1);
        chk("single_ready1", req1_ready_o, 0);
        push(1'b0, 8'd53);
        cyc();
        req0_valid_i = 1'b0;
        req0_a_i = 8'hAA;
        @(negedge clk);
        chk("exec_busy", busy_o, 1);
        chk("exec_rsp_valid", rsp_valid_o, 0);
        chk("exec_ready0", req0_ready_o, 0);
        cyc();
        @(negedge clk);
        chk("latency_rsp_valid", rsp_valid_o, 1);
        wait_done(16'd1, 10);

        do_reset();
        chk("reset_done_clear", done_cnt_o, 0);
        req0_a_i = 8'd50; req0_b_i = 8'd3;  req0_op_i = OP_SUB;
        req1_a_i = 8'd10; req1_b_i = 8'd20; req1_op_i = OP_ADD;
        push(1'b0, 8'd47);
        push(1'b1, 8'd30);
        run(1, 1, 20);
        wait_done(16'd2, 20);

        do_reset();
        req0_a_i = 8'd200; req0_b_i = 8'd100; req0_op_i = OP_ADD;
        req1_a_i = 8'd5;   req1_b_i = 8'd9;   req1_op_i = OP_SUB;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 8'd44);
            push(1'b1, 8'd252);
        end
        run(3, 3, 40);
        wait_done(16'd6, 20);

        do_reset();
        rsp_ready_i = 1'b0;
        req1_a_i = 8'd7; req1_b_i = 8'd9; req1_op_i = OP_SUB;
        req1_valid_i = 1'b1;
        @(negedge clk);
        chk("stall_ready1", req1_ready_o, 1);
        push(1'b1, 8'd254);
        cyc();
        req1_valid_i = 1'b0;
        req0_a_i = 8'd1; req0_b_i = 8'd1; req0_op_i = OP_ADD;
        req0_valid_i = 1'b1;
        @(negedge clk);
        chk("stall_exec_ready0", req0_ready_o, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid_o, 1);
            chk("stall_rsp_id", rsp_id_o, 1);
            chk("stall_rsp_res", rsp_res_o, 254);
            chk("stall_ready0", req0_ready_o, 0);
            chk("stall_ready1", req1_ready_o, 0);
            cyc();
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("held_valid_ready0", req0_ready_o, 1);
        push(1'b0, 8'd2);
        cyc();
        req0_valid_i = 1'b0;
        wait_done(16'd2, 10);

        do_reset();
        req0_a_i = 8'd1; req0_b_i = 8'd2; req0_op_i = OP_ADD;
        req0_valid_i = 1'b1;
        @(negedge clk);
        chk("abort_ready0", req0_ready_o, 1);
        cyc();
        req0_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        chk("abort_in_exec", busy_o, 1);
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_o, 0);
        chk("abort_rsp_valid", rsp_valid_o, 0);
        chk("abort_done", done_cnt_o, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid_o, 0);
        end

        cyc();
        req1_a_i = 8'd255; req1_b_i = 8'd1; req1_op_i = OP_ADD;
        push(1'b1, 8'd0);
        run(0, 1, 10);
        wait_done(16'd1, 10);
        cyc();
        force dut.r_done_cnt = 16'hFFFF;
        cyc();
        release dut.r_done_cnt;
        @(negedge clk);
        chk("preset_done", done_cnt_o, 16'hFFFF);
        cyc();
        req0_a_i = 8'd50; req0_b_i = 8'd3; req0_op_i = OP_ADD;
        push(1'b0, 8'd53);
        run(1, 0, 10);
        wait_done(16'd0, 10);
        @(negedge clk);
        chk("wrap_busy", busy_o, 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
